// File: rtl/mem_responder.sv
// Unified instruction/data memory behind the multicycle core's memory port.
// Optional misaligned-address error check enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [AW-1:0] r_idx;
  logic          r_mis;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic w_access;
  logic w_commit;
  logic w_mis_in;
  logic w_unused;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_mis_in = |i_adr[1:0];
  assign w_unused = ^i_adr[31:AW+2];
`else
  assign w_mis_in = 1'b0;
  assign w_unused = ^{i_adr[31:AW+2], i_adr[1:0]};
`endif

  // The access edge is the last WAIT cycle; reset on that edge must suppress the commit.
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_commit = w_access && r_we && !r_mis && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_state <= S_WAIT;
            r_cnt   <= 4'(WAIT);
            r_we    <= i_we;
            r_wdata <= i_write_data;
            r_idx   <= i_adr[AW+1:2];
            r_mis   <= w_mis_in;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
            r_err   <= r_mis;
            if (r_mis) begin
              r_rdata <= 32'd0;
            end else if (!r_we) begin
              r_rdata <= r_mem[r_idx];
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign o_read_data = r_rdata;
  assign o_ready     = (r_state == S_RESP);
  assign o_busy      = (r_state != S_IDLE);
  assign o_err       = r_err;

endmodule
